// File: rtl/expr_gen.sv
// Serializes a latched list of single-digit operands and binary operators into an
// ASCII character stream of the form digit (op digit)*, one character per handshake.
module expr_gen #(
  parameter int unsigned MAX_TERMS = 8
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic                       start,
  input  logic [3:0]                 nterms,
  input  logic [4*MAX_TERMS-1:0]     digits,
  input  logic [2*(MAX_TERMS-1)-1:0] ops,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [7:0]                 out_char,
  output logic                       out_last,
  output logic                       busy,
  output logic                       err
);

  localparam int unsigned DIG_W = 4 * MAX_TERMS;
  localparam int unsigned OPS_W = 2 * (MAX_TERMS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DIGIT = 2'd1,
    S_OPER  = 2'd2
  } state_e;

  state_e             state_q;
  logic [3:0]         idx_q;
  logic [3:0]         nterms_q;
  logic [DIG_W-1:0]   digits_q;
  logic [OPS_W-1:0]   ops_q;
  logic               out_valid_q;
  logic [7:0]         out_char_q;
  logic               out_last_q;
  logic               busy_q;
  logic               err_q;

  logic               bad_digit_c;
  logic               reject_c;
  logic [3:0]         idx_nx_c;
  logic [3:0]         last_idx_c;
  logic [3:0]         dig_nx_c;
  logic [1:0]         op_sel_c;

  function automatic logic [7:0] digit_char(input logic [3:0] d);
    return 8'h30 + {4'h0, d};
  endfunction

  function automatic logic [7:0] op_char(input logic [1:0] code);
    case (code)
      2'b00:   return 8'h2B;
      2'b01:   return 8'h2D;
      2'b10:   return 8'h2A;
      default: return 8'h2F;
    endcase
  endfunction

  // Only operands that will actually be emitted are range-checked.
  always_comb begin
    bad_digit_c = 1'b0;
    for (int unsigned i = 0; i < MAX_TERMS; i++) begin
      if ((i < 32'(nterms)) && (digits[4*i +: 4] > 4'd9)) bad_digit_c = 1'b1;
    end
  end

  assign reject_c   = (nterms == 4'd0) || (32'(nterms) > MAX_TERMS) || bad_digit_c;
  assign idx_nx_c   = idx_q + 4'd1;
  assign last_idx_c = nterms_q - 4'd1;
  assign dig_nx_c   = 4'(digits_q >> {idx_nx_c, 2'b00});
  assign op_sel_c   = 2'(ops_q >> {idx_q, 1'b0});

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      nterms_q    <= '0;
      digits_q    <= '0;
      ops_q       <= '0;
      out_valid_q <= 1'b0;
      out_char_q  <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (reject_c) begin
              err_q <= 1'b1;
            end else begin
              nterms_q    <= nterms;
              digits_q    <= digits;
              ops_q       <= ops;
              idx_q       <= '0;
              state_q     <= S_DIGIT;
              busy_q      <= 1'b1;
              out_valid_q <= 1'b1;
              out_char_q  <= digit_char(digits[3:0]);
              out_last_q  <= (nterms == 4'd1);
            end
          end
        end
        S_DIGIT: begin
          if (out_ready) begin
            if (out_last_q) begin
              state_q     <= S_IDLE;
              busy_q      <= 1'b0;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              out_char_q  <= '0;
            end else begin
              state_q    <= S_OPER;
              out_char_q <= op_char(op_sel_c);
            end
          end
        end
        S_OPER: begin
          if (out_ready) begin
            idx_q      <= idx_nx_c;
            state_q    <= S_DIGIT;
            out_char_q <= digit_char(dig_nx_c);
            out_last_q <= (idx_nx_c == last_idx_c);
          end
        end
        default: begin
          state_q     <= S_IDLE;
          busy_q      <= 1'b0;
          out_valid_q <= 1'b0;
          out_last_q  <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_char  = out_char_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule

// File: tb/tb_expr_gen.sv
// Scoreboard bench for expr_gen: stimulus pushes hand-written expected strings,
// a negedge monitor pops and compares on every handshake.
module tb_expr_gen;

  localparam int unsigned MT = 8;

  logic              clk = 1'b0;
  logic              clr;
  logic              start;
  logic [3:0]        nterms;
  logic [4*MT-1:0]   digits;
  logic [2*MT-3:0]   ops;
  logic              out_ready;
  logic              out_valid;
  logic [7:0]        out_char;
  logic              out_last;
  logic              busy;
  logic              err;

  int checks = 0;
  int errors = 0;
  int xfers  = 0;
  logic [8:0] exp_q[$];
  logic toggle_en = 1'b0;
  int   tog_k = 0;
  logic [3:0] tog_pat = 4'b1001;

  expr_gen #(.MAX_TERMS(MT)) dut (
    .clk(clk), .clr(clr), .start(start), .nterms(nterms), .digits(digits),
    .ops(ops), .out_ready(out_ready), .out_valid(out_valid), .out_char(out_char),
    .out_last(out_last), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (toggle_en) begin
      out_ready = tog_pat[tog_k];
      tog_k = (tog_k + 1) % 4;
    end
  endtask

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back({(i == s.len() - 1), 8'(s[i])});
  endtask

  task automatic push_partial(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back({1'b0, 8'(s[i])});
  endtask

  task automatic start_expr(input logic [3:0] nt, input logic [4*MT-1:0] dg,
                            input logic [2*MT-3:0] op);
    nterms = nt; digits = dg; ops = op; start = 1'b1;
    tick();
    start = 1'b0; nterms = 4'hF; digits = '1; ops = '1;
  endtask

  task automatic wait_idle(input string name, input int exp_cyc);
    int cyc = 0;
    while (busy && cyc < 200) begin
      cyc++;
      tick();
    end
    if (cyc >= 200) chk({name, "_timeout"}, 1, 0);
    if (exp_cyc >= 0) chk({name, "_busy_cycles"}, cyc, exp_cyc);
    chk({name, "_queue_left"}, exp_q.size(), 0);
    chk({name, "_valid_after"}, int'(out_valid), 0);
  endtask

  task automatic reject(input string name, input logic [3:0] nt, input logic [4*MT-1:0] dg);
    nterms = nt; digits = dg; ops = '0; start = 1'b1;
    tick();
    start = 1'b0;
    chk({name, "_err"}, int'(err), 1);
    chk({name, "_valid"}, int'(out_valid), 0);
    chk({name, "_busy"}, int'(busy), 0);
    tick();
    chk({name, "_err_pulse"}, int'(err), 0);
    chk({name, "_busy2"}, int'(busy), 0);
  endtask

  // Monitor: checks hold-stability under backpressure and pops on every transfer.
  logic       held_v = 1'b0;
  logic [8:0] held_d = '0;
  always @(negedge clk) begin
    if (clr) begin
      held_v = 1'b0;
    end else begin
      if (held_v) chk("hold_stable", {out_valid, out_last, out_char}, {1'b1, held_d});
      if (out_valid && out_ready) begin
        xfers++;
        if (exp_q.size() == 0) begin
          chk("unexpected_char", int'(out_char), 0);
        end else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          chk("char", {out_last, out_char}, e);
        end
      end
      held_v = out_valid && !out_ready;
      held_d = {out_last, out_char};
    end
  end

  initial begin
    int x0;
    clr = 1'b1; start = 1'b0; nterms = '0; digits = '0; ops = '0; out_ready = 1'b1;
    tick(); tick();
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_char", int'(out_char), 0);
    chk("rst_last", int'(out_last), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(err), 0);
    clr = 1'b0;
    tick();

    // Basic stream, full throughput
    push_str("1+2*5");
    start_expr(4'd3, 32'h521, 14'b1000);
    wait_idle("t1", 5);

    // Backpressure 1,0,0,1 pattern
    x0 = xfers;
    toggle_en = 1'b1; tog_k = 0;
    push_str("1+2*5");
    start_expr(4'd3, 32'h521, 14'b1000);
    wait_idle("t2", -1);
    chk("t2_xfers", xfers - x0, 5);
    toggle_en = 1'b0; out_ready = 1'b1;
    tick();

    // Single operand
    push_str("9");
    start_expr(4'd1, 32'h9, 14'b0);
    wait_idle("t3", 1);

    // Maximum length expression
    push_str("0-1*2/3+4-5*6/7");
    start_expr(4'd8, 32'h76543210, 14'b11_10_01_00_11_10_01);
    wait_idle("tmax", 15);

    // Rejected starts
    reject("t4_digit", 4'd2, 32'hA1);
    reject("t4_zero", 4'd0, 32'h1);
    reject("t4_over", 4'(MT + 1), 32'h1);
    chk("t4_no_xfer", exp_q.size(), 0);

    // Start while busy is ignored; start in first idle cycle is accepted
    push_str("3-4/0*7");
    start_expr(4'd4, 32'h7043, 14'b101101);
    tick(); tick();
    nterms = 4'd2; digits = 32'h11; ops = '0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t5_busy_start_err", int'(err), 0);
    wait_idle("t5", -1);
    push_str("6/8");
    start_expr(4'd2, 32'h86, 14'b11);
    chk("t5_idle_accept", int'(busy), 1);
    wait_idle("t5b", 3);

    // clr mid-stream truncates, fresh stream restarts at operand 0
    push_partial("8*");
    start_expr(4'd4, 32'h2468, 14'b000110);
    tick(); tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("t6_valid", int'(out_valid), 0);
    chk("t6_busy", int'(busy), 0);
    chk("t6_err", int'(err), 0);
    chk("t6_queue", exp_q.size(), 0);
    push_str("2-1*0/9");
    start_expr(4'd4, 32'h9012, 14'b111001);
    wait_idle("t6b", 7);

    tick(); tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
